weight_stream_loader: RTL
=========================

# weight_stream_loader

Writer-side front end for the per-neuron weight memories (W_Mem_<layer>_<neuron>). It accepts a valid/ready word stream carrying one header word and then exactly numWeight weights. It drives the memories' write port (wen, wadd, win) together with a registered layer/neuron select, so the decode fabric enables exactly one memory. Weights can therefore be loaded at run time instead of being fixed at elaboration.

## Interface
- numWeight, 30, weights per neuron frame
- addressWidth, $clog2(numWeight), width of wadd
- dataWidth, 16, weight/stream word width (signed fixed point, passed through untouched)
- layerWidth, 3, width of layer_sel
- neuronWidth, 6, width of neuron_sel; layerWidth+neuronWidth <= dataWidth
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  dataWidth  header or weight word
- s_last  in  1  marks final word of a frame
- wen  out  1  memory write enable, one cycle per weight
- wadd  out  addressWidth  memory write address
- win  out  dataWidth  memory write data
- layer_sel  out  layerWidth  target layer, held between headers
- neuron_sel  out  neuronWidth  target neuron, held between headers
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful frame
- err  out  1  sticky protocol-fault flag

## Operation
- Handshake: a word transfers on a posedge where s_valid && s_ready. s_data and s_last are sampled only on a transfer.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE: s_ready=1. The first transfer is the header.
  - neuron_sel <= s_data[neuronWidth-1:0].
  - layer_sel <= s_data[neuronWidth+layerWidth-1:neuronWidth].
  - err <= 0; counter <= 0; next state LOAD.
  - Header with s_last=1: err <= 1, selects still update, state stays IDLE.
- LOAD: s_ready=1. Each transfer writes weight k = counter: registered wen=1, wadd=k, win=s_data. Counter increments.
  - k < numWeight-1 with s_last=1: the word is written, err <= 1, next state IDLE (early termination).
  - k = numWeight-1 with s_last=1: the word is written, next state DONE.
  - k = numWeight-1 with s_last=0: the word is written, err <= 1, next state DRAIN.
- DRAIN: s_ready=1. Words are discarded (no wen). A transfer with s_last=1 returns to IDLE.
- DONE: s_ready=0, done=1 for exactly one cycle, then IDLE.
- Counter: addressWidth bits, ranges 0..numWeight-1, never wraps. wadd never exceeds numWeight-1.
- No arithmetic on data; win is bit-identical to the accepted s_data.
- Gaps in s_valid are allowed anywhere. Counter and outputs hold during gaps.

## Timing
- Reset values: s_ready=0 while rst_n=0, then 1 (IDLE). wen=0, wadd=0, win=0, layer_sel=0, neuron_sel=0, busy=0, done=0, err=0.
- Weight transfer at edge N produces wen/wadd/win valid during cycle N+1 (latency 1). wen is deasserted in every cycle without a preceding weight transfer.
- Final weight at edge N:
  - cycle N+1: final wen, done=1, s_ready=0.
  - cycle N+2: IDLE, s_ready=1.
- Minimum frame occupancy is numWeight+2 cycles (header, weights, DONE).
- layer_sel/neuron_sel change only on a header transfer. They are stable for the cycle after the header and for every wen cycle of that frame.
- Reset asserted mid-frame: immediate return to IDLE, wen drops asynchronously, partial frame abandoned. Already-written words are not rolled back.
- busy rises the cycle after the header and falls in the cycle IDLE is re-entered.

## Test plan
- Normal frame: header {layer=2, neuron=23} (s_data=0x0097), then weights 0x0981, 0x070A, … (30 words), s_last on word 30. Required response:
  - layer_sel=2, neuron_sel=23.
  - 30 wen pulses with wadd 0..29 and matching win.
  - done=1 once, err=0.
- Random s_valid gaps (about 50% duty): identical write sequence to the gap-free case, counter holds in idle cycles, no extra wen.
- Early s_last on weight index 9: 10 writes (wadd 0..9), err=1, no done, busy=0 next cycle. The next header clears err.
- Missing s_last on weight 29, then 3 extra words with s_last on the third: 30 writes, err=1, extra words produce no wen, back to IDLE after the third.
- rst_n low after weight 12: all outputs return to reset values immediately. A following full frame completes with done=1, err=0.
- Back-to-back frames (neuron 22, then neuron 23) with s_valid held high:
  - s_ready low exactly one cycle between frames.
  - neuron_sel switches only at the second header.

Source files
------------

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: header + weight stream to per-neuron weight-memory write port
module weight_stream_loader #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int layerWidth   = 3,
  parameter int neuronWidth  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [dataWidth-1:0]    s_data,
  input  logic                    s_last,
  output logic                    wen,
  output logic [addressWidth-1:0] wadd,
  output logic [dataWidth-1:0]    win,
  output logic [layerWidth-1:0]   layer_sel,
  output logic [neuronWidth-1:0]  neuron_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
  state_t                  state_q, state_d;
  logic [addressWidth-1:0] cnt_q, cnt_d, wadd_q, wadd_d;
  logic [dataWidth-1:0]    win_q, win_d;
  logic [layerWidth-1:0]   layer_q, layer_d;
  logic [neuronWidth-1:0]  neuron_q, neuron_d;
  logic                    wen_q, wen_d, err_q, err_d;
  logic                    xfer;
  assign s_ready    = rst_n && (state_q != DONE);
  assign xfer       = s_valid && s_ready;
  assign wen        = wen_q;
  assign wadd       = wadd_q;
  assign win        = win_q;
  assign layer_sel  = layer_q;
  assign neuron_sel = neuron_q;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign err        = err_q;
  // next-state and datapath: header latches selects, LOAD writes one weight per transfer, counter saturates at the last index
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wadd_d   = wadd_q;
    win_d    = win_q;
    wen_d    = 1'b0;
    err_d    = err_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    case (state_q)
      IDLE: if (xfer) begin
        neuron_d = s_data[neuronWidth-1:0];
        layer_d  = s_data[neuronWidth+layerWidth-1:neuronWidth];
        cnt_d    = '0;
        err_d    = s_last;
        state_d  = s_last ? IDLE : LOAD;
      end
      LOAD: if (xfer) begin
        wen_d  = 1'b1;
        wadd_d = cnt_q;
        win_d  = s_data;
        if (cnt_q == LAST_IDX) begin
          state_d = s_last ? DONE : DRAIN;
          err_d   = err_q || !s_last;
        end else begin
          cnt_d = cnt_q + addressWidth'(1);
          if (s_last) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      DRAIN: if (xfer && s_last) state_d = IDLE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any partial frame and drops wen at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wadd_q   <= '0;
      win_q    <= '0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      layer_q  <= '0;
      neuron_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wadd_q   <= wadd_d;
      win_q    <= win_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
    end
  end
endmodule
